// File: rtl/fw_message_serializer_pkg.sv
// Shared constants for the firmware-test message serializer: frame characters,
// FSM encoding, event-kind indices with their service priority, and string depth.
package fw_message_serializer_pkg;

    localparam int unsigned STR_DEPTH_DEFAULT = 64;
    localparam int unsigned STR_AW            = 6;
    localparam logic [7:0]  EOL_DEFAULT       = 8'h0A;

    localparam logic [7:0] TYPE_R = 8'h52;
    localparam logic [7:0] TYPE_W = 8'h57;
    localparam logic [7:0] TYPE_E = 8'h45;
    localparam logic [7:0] TYPE_P = 8'h50;
    localparam logic [7:0] TYPE_F = 8'h46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_CODE,
        ST_STR,
        ST_EOL
    } state_t;

    typedef enum logic [1:0] {
        K_REPORT  = 2'd0,
        K_WARNING = 2'd1,
        K_ERROR   = 2'd2,
        K_COMPARE = 2'd3
    } kind_t;

    localparam int unsigned NUM_KINDS = 4;

    // Service order: error > warning > compare > report.
    function automatic kind_t pick_kind(input logic [NUM_KINDS-1:0] pend);
        if (pend[K_ERROR])   return K_ERROR;
        if (pend[K_WARNING]) return K_WARNING;
        if (pend[K_COMPARE]) return K_COMPARE;
        return K_REPORT;
    endfunction

endpackage

// File: rtl/fw_message_serializer_if.sv
// Bundle of event inputs, string-memory write port, byte stream and status
// outputs between the firmware-test Wishbone block, the serializer and the log sink.
interface fw_message_serializer_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 new_report;
    logic                 new_warning;
    logic                 new_error;
    logic                 new_compare;
    logic [31:0]          report_reg;
    logic [31:0]          warning_reg;
    logic [31:0]          error_reg;
    logic [31:0]          expected_reg;
    logic [31:0]          measured_reg;
    logic                 write_mem;
    logic [7:0]           data;
    logic [5:0]           index;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 compare_fail;
    logic [CNT_WIDTH-1:0] warning_count;
    logic [CNT_WIDTH-1:0] error_count;
    logic [CNT_WIDTH-1:0] fail_count;
    logic [7:0]           dropped_count;

    modport master (
        input  new_report, new_warning, new_error, new_compare,
        input  report_reg, warning_reg, error_reg, expected_reg, measured_reg,
        input  write_mem, data, index, out_ready,
        output out_data, out_valid, busy, compare_fail,
        output warning_count, error_count, fail_count, dropped_count
    );

    modport slave (
        output new_report, new_warning, new_error, new_compare,
        output report_reg, warning_reg, error_reg, expected_reg, measured_reg,
        output write_mem, data, index, out_ready,
        input  out_data, out_valid, busy, compare_fail,
        input  warning_count, error_count, fail_count, dropped_count
    );
endinterface

// File: rtl/fw_string_mem.sv
// Message string store: flop array, write at the clock edge, combinational read.
// Deliberately not reset; firmware always rewrites the string before use.
module fw_string_mem
    import fw_message_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = STR_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STR_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [STR_AW-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fw_message_serializer.sv
// Frames pending firmware events as TYPE/CODE/STRING/EOL bytes; first byte valid
// 2 edges after a strobe, out_data held while stalled, 1-cycle bubble between frames.
module fw_message_serializer
    import fw_message_serializer_pkg::*;
#(
    parameter int unsigned STR_DEPTH = STR_DEPTH_DEFAULT,
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [7:0]  EOL_CHAR  = EOL_DEFAULT
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    fw_message_serializer_if.master bus
);
    logic [NUM_KINDS-1:0] new_vec, pending, consume, drop;
    logic [31:0]          snap_rep, snap_warn, snap_err, snap_exp, snap_meas;
    logic [7:0]           dropped_cnt;
    logic [2:0]           drop_n;
    logic [8:0]           drop_sum;

    state_t               state;
    kind_t                frame_kind, sel_kind;
    logic [63:0]          frame_code, sel_code;
    logic [7:0]           sel_type, out_dat, rd_dat;
    logic                 sel_mismatch, start, xfer, out_vld, cmp_fail;
    logic [2:0]           byte_cnt, last_code;
    logic [STR_AW-1:0]    str_idx, rd_addr;
    logic [CNT_WIDTH-1:0] warn_cnt, err_cnt, fail_cnt;

    assign new_vec  = {bus.new_compare, bus.new_error, bus.new_warning, bus.new_report};
    assign sel_kind = pick_kind(pending);
    assign start    = (state == ST_IDLE) && (|pending);
    assign consume  = start ? (NUM_KINDS'(1) << sel_kind) : '0;
    // A capture only counts as a drop if the old event is not leaving this edge.
    assign drop     = new_vec & pending & ~consume;
    assign drop_n   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    assign drop_sum = {1'b0, dropped_cnt} + {6'd0, drop_n};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pending     <= '0;
            dropped_cnt <= '0;
            snap_rep    <= '0;
            snap_warn   <= '0;
            snap_err    <= '0;
            snap_exp    <= '0;
            snap_meas   <= '0;
        end else begin
            pending     <= new_vec | (pending & ~consume);
            dropped_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (new_vec[K_REPORT])  snap_rep  <= bus.report_reg;
            if (new_vec[K_WARNING]) snap_warn <= bus.warning_reg;
            if (new_vec[K_ERROR])   snap_err  <= bus.error_reg;
            if (new_vec[K_COMPARE]) begin
                snap_exp  <= bus.expected_reg;
                snap_meas <= bus.measured_reg;
            end
        end
    end

    always_comb begin
        sel_code     = '0;
        sel_type     = TYPE_R;
        sel_mismatch = (snap_exp != snap_meas);
        case (sel_kind)
            K_REPORT:  begin sel_code = {snap_rep, 32'h0};  sel_type = TYPE_R; end
            K_WARNING: begin sel_code = {snap_warn, 32'h0}; sel_type = TYPE_W; end
            K_ERROR:   begin sel_code = {snap_err, 32'h0};  sel_type = TYPE_E; end
            K_COMPARE: begin
                sel_code = {snap_exp, snap_meas};
                sel_type = sel_mismatch ? TYPE_F : TYPE_P;
            end
            default:   begin sel_code = '0; sel_type = TYPE_R; end
        endcase
    end

    assign xfer      = out_vld & bus.out_ready;
    assign last_code = (frame_kind == K_COMPARE) ? 3'd7 : 3'd3;
    // The string pointer looks one byte ahead so the next byte is ready at the transfer edge.
    assign rd_addr   = (state == ST_STR) ? (str_idx + STR_AW'(1)) : '0;

    fw_string_mem #(.DEPTH(STR_DEPTH)) u_str_mem (
        .clk   (wb_clk_i),
        .we    (bus.write_mem),
        .waddr (bus.index),
        .wdata (bus.data),
        .raddr (rd_addr),
        .rdata (rd_dat)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            frame_kind <= K_REPORT;
            frame_code <= '0;
            byte_cnt   <= '0;
            str_idx    <= '0;
            out_dat    <= '0;
            out_vld    <= 1'b0;
            cmp_fail   <= 1'b0;
            warn_cnt   <= '0;
            err_cnt    <= '0;
            fail_cnt   <= '0;
        end else begin
            cmp_fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_kind <= sel_kind;
                        frame_code <= sel_code;
                        out_dat    <= sel_type;
                        out_vld    <= 1'b1;
                        byte_cnt   <= '0;
                        state      <= ST_TYPE;
                        if (sel_kind == K_WARNING && ~&warn_cnt) warn_cnt <= warn_cnt + CNT_WIDTH'(1);
                        if (sel_kind == K_ERROR && ~&err_cnt)    err_cnt  <= err_cnt + CNT_WIDTH'(1);
                        if (sel_kind == K_COMPARE && sel_mismatch) begin
                            cmp_fail <= 1'b1;
                            if (~&fail_cnt) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_TYPE: begin
                    if (xfer) begin
                        out_dat    <= frame_code[63:56];
                        frame_code <= frame_code << 8;
                        byte_cnt   <= '0;
                        state      <= ST_CODE;
                    end
                end
                ST_CODE: begin
                    if (xfer) begin
                        if (byte_cnt == last_code) begin
                            str_idx <= '0;
                            if (rd_dat == 8'h00) begin
                                out_dat <= EOL_CHAR;
                                state   <= ST_EOL;
                            end else begin
                                out_dat <= rd_dat;
                                state   <= ST_STR;
                            end
                        end else begin
                            out_dat    <= frame_code[63:56];
                            frame_code <= frame_code << 8;
                            byte_cnt   <= byte_cnt + 3'd1;
                        end
                    end
                end
                ST_STR: begin
                    if (xfer) begin
                        if (str_idx == STR_AW'(STR_DEPTH - 1) || rd_dat == 8'h00) begin
                            out_dat <= EOL_CHAR;
                            state   <= ST_EOL;
                        end else begin
                            out_dat <= rd_dat;
                            str_idx <= str_idx + STR_AW'(1);
                        end
                    end
                end
                ST_EOL: begin
                    if (xfer) begin
                        out_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    out_vld <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_data      = out_dat;
    assign bus.out_valid     = out_vld;
    assign bus.busy          = (state != ST_IDLE) | (|pending);
    assign bus.compare_fail  = cmp_fail;
    assign bus.warning_count = warn_cnt;
    assign bus.error_count   = err_cnt;
    assign bus.fail_count    = fail_cnt;
    assign bus.dropped_count = dropped_cnt;
endmodule

// File: tb/tb_fw_message_serializer.sv
// Bench for fw_message_serializer: directed scenarios plus randomized frames,
// checked against a byte-queue frame model built from the framing rules.
module tb_fw_message_serializer;
    localparam int CW = 16;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 wb_clk_i = ~wb_clk_i;

    fw_message_serializer_if #(.CNT_WIDTH(CW)) bus ();

    fw_message_serializer #(.STR_DEPTH(64), .CNT_WIDTH(CW), .EOL_CHAR(8'h0A)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [7:0] tb_mem [64];
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         rx_cyc [$];
    int exp_warn = 0, exp_err = 0, exp_fail = 0, exp_drop = 0;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && bus.out_valid && bus.out_ready) begin
            rx_q.push_back(bus.out_data);
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic write_byte(input int idx, input logic [7:0] b);
        bus.write_mem = 1'b1;
        bus.index     = 6'(idx);
        bus.data      = b;
        tick();
        bus.write_mem = 1'b0;
        tb_mem[idx]   = b;
    endtask

    // Frame model: type, code bytes MSB first, string up to first NUL (max 64), EOL.
    task automatic model_frame(input logic [7:0] t, input logic [63:0] code, input int ncode);
        exp_q.push_back(t);
        for (int i = 0; i < ncode; i++) exp_q.push_back(code[63-8*i -: 8]);
        for (int i = 0; i < 64; i++) begin
            if (tb_mem[i] == 8'h00) break;
            exp_q.push_back(tb_mem[i]);
        end
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input int budget, output bit timed_out, output int cf);
        timed_out = 1'b1;
        cf = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.compare_fail) cf++;
            if (i >= 1 && !bus.busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) tick();
        wb_rst_i = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.compare_fail !== 1'b0) begin n_bad++; $display("FAIL reset_compare_fail: got %b want 0", bus.compare_fail); end
        n_cmp++; if ({bus.warning_count, bus.error_count, bus.fail_count, bus.dropped_count} !== '0) begin
            n_bad++; $display("FAIL reset_counters: got %h/%h/%h/%h want all 0", bus.warning_count, bus.error_count, bus.fail_count, bus.dropped_count);
        end
    endtask

    task automatic test_report();
        bit to; int cf, bad;
        clear_q();
        write_byte(0, 8'h4F); write_byte(1, 8'h4B); write_byte(2, 8'h00);
        bus.report_reg = 32'h0000_0012;
        model_frame(8'h52, {32'h0000_0012, 32'h0}, 4);
        bus.new_report = 1'b1; tick(); bus.new_report = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL report_latency_early: out_valid %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h52) begin
            n_bad++; $display("FAIL report_first_byte: valid %b data %h want 1/52", bus.out_valid, bus.out_data);
        end
        wait_idle(100, to, cf);
        n_cmp++; if (to) begin n_bad++; $display("FAIL report_timeout: busy never dropped"); end
        bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL report_stream: %0d bytes got, %0d wanted, %0d bad", rx_q.size(), exp_q.size(), bad); end
        bad = 0;
        for (int i = 0; i < rx_cyc.size(); i++) if (rx_cyc[i] != rx_cyc[0] + i) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL report_back_to_back: %0d gaps want 0", bad); end
    endtask

    task automatic test_compare();
        bit to; int cf, bad;
        write_byte(0, 8'h00);
        for (int pass = 0; pass < 2; pass++) begin
            clear_q();
            bus.expected_reg = 32'hDEAD_BEEF;
            bus.measured_reg = (pass == 0) ? 32'hDEAD_BEEF : 32'h0;
            model_frame((pass == 0) ? 8'h50 : 8'h46, {bus.expected_reg, bus.measured_reg}, 8);
            if (pass == 1) exp_fail++;
            bus.new_compare = 1'b1; tick(); bus.new_compare = 1'b0;
            wait_idle(100, to, cf);
            n_cmp++; if (to) begin n_bad++; $display("FAIL compare_timeout pass %0d", pass); end
            bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL compare_stream pass %0d: %0d got %0d wanted %0d bad", pass, rx_q.size(), exp_q.size(), bad); end
            n_cmp++; if (cf != pass) begin n_bad++; $display("FAIL compare_fail_pulses pass %0d: got %0d want %0d", pass, cf, pass); end
            n_cmp++; if (bus.fail_count !== CW'(exp_fail)) begin n_bad++; $display("FAIL compare_fail_count: got %0d want %0d", bus.fail_count, exp_fail); end
        end
    endtask

    task automatic test_error_warning();
        bit to; int cf, bad;
        clear_q();
        bus.error_reg = 32'h1; bus.warning_reg = 32'h2;
        model_frame(8'h45, {32'h1, 32'h0}, 4);
        model_frame(8'h57, {32'h2, 32'h0}, 4);
        exp_err++; exp_warn++;
        bus.new_error = 1'b1; bus.new_warning = 1'b1; tick();
        bus.new_error = 1'b0; bus.new_warning = 1'b0;
        wait_idle(100, to, cf);
        n_cmp++; if (to) begin n_bad++; $display("FAIL errwarn_timeout"); end
        bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL errwarn_stream: %0d got %0d wanted %0d bad", rx_q.size(), exp_q.size(), bad); end
        n_cmp++; if (rx_q.size() == 12 && rx_cyc[6] - rx_cyc[5] != 2) begin
            n_bad++; $display("FAIL errwarn_bubble: gap %0d want 2", rx_cyc[6] - rx_cyc[5]);
        end
        n_cmp++; if (bus.error_count !== CW'(exp_err) || bus.warning_count !== CW'(exp_warn) || bus.dropped_count !== 8'(exp_drop)) begin
            n_bad++; $display("FAIL errwarn_counts: e %0d w %0d d %0d want %0d %0d %0d", bus.error_count, bus.warning_count, bus.dropped_count, exp_err, exp_warn, exp_drop);
        end
    endtask

    task automatic test_stall_drop();
        bit to; int cf, bad; logic [7:0] d0;
        clear_q();
        bus.out_ready = 1'b0;
        bus.error_reg = 32'h3;
        model_frame(8'h45, {32'h3, 32'h0}, 4);
        model_frame(8'h52, {32'h6, 32'h0}, 4);
        exp_err++; exp_drop++;
        bus.new_error = 1'b1; tick(); bus.new_error = 1'b0;
        tick();
        d0 = bus.out_data;
        bad = 0;
        bus.report_reg = 32'h5; bus.new_report = 1'b1; tick();
        if (bus.out_valid !== 1'b1 || bus.out_data !== d0) bad++;
        bus.report_reg = 32'h6; tick(); bus.new_report = 1'b0;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d0) bad++;
        repeat (3) begin tick(); if (bus.out_valid !== 1'b1 || bus.out_data !== d0) bad++; end
        n_cmp++; if (bad != 0 || d0 !== 8'h45) begin n_bad++; $display("FAIL stall_hold: %0d unstable samples, held %h want 45", bad, d0); end
        bus.out_ready = 1'b1;
        wait_idle(100, to, cf);
        n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout"); end
        bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_stream: %0d got %0d wanted %0d bad", rx_q.size(), exp_q.size(), bad); end
        n_cmp++; if (bus.dropped_count !== 8'(exp_drop)) begin n_bad++; $display("FAIL stall_dropped: got %0d want %0d", bus.dropped_count, exp_drop); end
    endtask

    task automatic test_full_string();
        bit to; int cf, bad; logic [31:0] code;
        clear_q();
        for (int i = 0; i < 64; i++) write_byte(i, 8'h41);
        code = $urandom;
        bus.report_reg = code;
        model_frame(8'h52, {code, 32'h0}, 4);
        bus.new_report = 1'b1; tick(); bus.new_report = 1'b0;
        wait_idle(200, to, cf);
        n_cmp++; if (to) begin n_bad++; $display("FAIL fullstr_timeout"); end
        n_cmp++; if (rx_q.size() != 70) begin n_bad++; $display("FAIL fullstr_len: got %0d want 70", rx_q.size()); end
        bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL fullstr_stream: %0d bad bytes", bad); end
    endtask

    task automatic test_reset_mid_frame();
        bit to; int cf, bad;
        clear_q();
        bus.report_reg = 32'hA5A5_0001;
        bus.new_report = 1'b1; tick(); bus.new_report = 1'b0;
        repeat (9) tick();
        bus.warning_reg = 32'h77; bus.new_warning = 1'b1; tick(); bus.new_warning = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        exp_warn = 0; exp_err = 0; exp_fail = 0; exp_drop = 0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_async: valid %b busy %b want 0/0", bus.out_valid, bus.busy);
        end
        n_cmp++; if ({bus.warning_count, bus.error_count, bus.fail_count, bus.dropped_count} !== '0) begin
            n_bad++; $display("FAIL midrst_counters: %0d/%0d/%0d/%0d want 0", bus.warning_count, bus.error_count, bus.fail_count, bus.dropped_count);
        end
        tick(); tick();
        wb_rst_i = 1'b0;
        tick();
        clear_q();
        write_byte(0, 8'h5A); write_byte(1, 8'h00);
        bus.report_reg = 32'h0BAD_F00D;
        model_frame(8'h52, {32'h0BAD_F00D, 32'h0}, 4);
        bus.new_report = 1'b1; tick(); bus.new_report = 1'b0;
        wait_idle(100, to, cf);
        n_cmp++; if (to) begin n_bad++; $display("FAIL midrst_timeout"); end
        bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midrst_stream: %0d got %0d wanted %0d bad", rx_q.size(), exp_q.size(), bad); end
    endtask

    task automatic test_random();
        int len, kind, bad, viol, cf, budget;
        bit done, stalled;
        logic [7:0] held;
        logic [31:0] a, b;
        for (int it = 0; it < 12; it++) begin
            clear_q();
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) write_byte(i, 8'($urandom_range(1, 255)));
            write_byte(len, 8'h00);
            kind = $urandom_range(0, 3);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            case (kind)
                0: begin bus.report_reg = a;  model_frame(8'h52, {a, 32'h0}, 4); end
                1: begin bus.warning_reg = a; model_frame(8'h57, {a, 32'h0}, 4); exp_warn++; end
                2: begin bus.error_reg = a;   model_frame(8'h45, {a, 32'h0}, 4); exp_err++; end
                default: begin
                    bus.expected_reg = a; bus.measured_reg = b;
                    model_frame((a == b) ? 8'h50 : 8'h46, {a, b}, 8);
                    if (a != b) exp_fail++;
                end
            endcase
            bus.new_report  = (kind == 0);
            bus.new_warning = (kind == 1);
            bus.new_error   = (kind == 2);
            bus.new_compare = (kind == 3);
            tick();
            bus.new_report = 1'b0; bus.new_warning = 1'b0; bus.new_error = 1'b0; bus.new_compare = 1'b0;
            done = 1'b0; stalled = 1'b0; held = '0; viol = 0; cf = 0; budget = 0;
            while (!done && budget < 400) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                stalled = bus.out_valid && !bus.out_ready;
                held = bus.out_data;
                tick();
                budget++;
                if (bus.compare_fail) cf++;
                if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held)) viol++;
                if (budget > 1 && !bus.busy) done = 1'b1;
            end
            bus.out_ready = 1'b1;
            n_cmp++; if (!done) begin n_bad++; $display("FAIL rand_timeout it %0d", it); end
            n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rand_hold it %0d: %0d violations want 0", it, viol); end
            bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rand_stream it %0d kind %0d: %0d got %0d wanted %0d bad", it, kind, rx_q.size(), exp_q.size(), bad); end
            n_cmp++; if (cf != ((kind == 3 && a != b) ? 1 : 0)) begin n_bad++; $display("FAIL rand_cmp_pulse it %0d: got %0d", it, cf); end
            n_cmp++; if (bus.warning_count !== CW'(exp_warn) || bus.error_count !== CW'(exp_err) || bus.fail_count !== CW'(exp_fail)) begin
                n_bad++; $display("FAIL rand_counts it %0d: w %0d e %0d f %0d want %0d %0d %0d", it, bus.warning_count, bus.error_count, bus.fail_count, exp_warn, exp_err, exp_fail);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 8'h00;
        bus.new_report = 1'b0; bus.new_warning = 1'b0; bus.new_error = 1'b0; bus.new_compare = 1'b0;
        bus.report_reg = '0; bus.warning_reg = '0; bus.error_reg = '0;
        bus.expected_reg = '0; bus.measured_reg = '0;
        bus.write_mem = 1'b0; bus.data = '0; bus.index = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_report();
        test_compare();
        test_error_warning();
        test_stall_drop();
        test_full_string();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
